// File: rtl/rv_hazard_ctrl.sv
// Hazard/forwarding controller for the pipelined RV32I core: tracks in-flight
// destinations, selects EX operand sources and drives stall/flush/freeze controls.
module rv_hazard_ctrl #(
  parameter int XLEN      = 32,
  parameter int RA_W      = 5,
  parameter int FWD_EN    = 1,
  parameter int RF_BYPASS = 1,
  parameter int BR_STAGE  = 2,
  parameter int CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             br_taken,
  input  logic             mem_wait,
  input  logic [XLEN-1:0]  ex_rd1,
  input  logic [XLEN-1:0]  ex_rd2,
  input  logic [XLEN-1:0]  mem_result,
  input  logic [XLEN-1:0]  wb_result,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_clr,
  output logic             idex_clr,
  output logic             exmem_clr,
  output logic             pipe_en,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [XLEN-1:0]  ex_opa,
  output logic [XLEN-1:0]  ex_opb,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // EX keeps the full entry (it is the forwarding consumer); MEM/WB only need producer fields
  logic            sb_ex_v, sb_ex_use1, sb_ex_use2, sb_ex_rw, sb_ex_ld;
  logic [RA_W-1:0] sb_ex_rd, sb_ex_rs1, sb_ex_rs2;
  logic            sb_mem_v, sb_mem_rw, sb_mem_ld;
  logic [RA_W-1:0] sb_mem_rd;
  logic            sb_wb_v, sb_wb_rw;
  logic [RA_W-1:0] sb_wb_rd;

  logic id_hit_ex, id_hit_mem, id_hit_wb, hazard;
  logic do_stall, do_flush;
  logic ex_a_mem, ex_a_wb, ex_b_mem, ex_b_wb;

  function automatic logic hit(input logic v, input logic rw, input logic [RA_W-1:0] rd,
                               input logic [RA_W-1:0] src, input logic use_src);
    return v & rw & (rd != '0) & (rd == src) & use_src;
  endfunction

  always_comb begin
    id_hit_ex  = id_valid & (hit(sb_ex_v, sb_ex_rw, sb_ex_rd, id_rs1, id_use1) |
                             hit(sb_ex_v, sb_ex_rw, sb_ex_rd, id_rs2, id_use2));
    id_hit_mem = id_valid & (hit(sb_mem_v, sb_mem_rw, sb_mem_rd, id_rs1, id_use1) |
                             hit(sb_mem_v, sb_mem_rw, sb_mem_rd, id_rs2, id_use2));
    id_hit_wb  = id_valid & (hit(sb_wb_v, sb_wb_rw, sb_wb_rd, id_rs1, id_use1) |
                             hit(sb_wb_v, sb_wb_rw, sb_wb_rd, id_rs2, id_use2));
    // Without a write-through regfile a WB producer is still invisible to the ID read
    if (FWD_EN != 0)
      hazard = (id_hit_ex & sb_ex_ld) | ((RF_BYPASS == 0) & id_hit_wb);
    else
      hazard = id_hit_ex | id_hit_mem | ((RF_BYPASS == 0) & id_hit_wb);
  end

  always_comb begin
    pc_en     = 1'b1;
    ifid_en   = 1'b1;
    pipe_en   = 1'b1;
    ifid_clr  = 1'b0;
    idex_clr  = 1'b0;
    exmem_clr = 1'b0;
    do_stall  = 1'b0;
    do_flush  = 1'b0;
    if (mem_wait) begin
      pc_en   = 1'b0;
      ifid_en = 1'b0;
      pipe_en = 1'b0;
    end else if (br_taken) begin
      ifid_clr  = 1'b1;
      idex_clr  = 1'b1;
      exmem_clr = (BR_STAGE == 3);
      do_flush  = 1'b1;
    end else if (hazard) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_clr = 1'b1;
      do_stall = 1'b1;
    end
  end

  // A load sitting in MEM is never a forwarding source; the load-use stall keeps it out of reach
  always_comb begin
    ex_a_mem = (FWD_EN != 0) & sb_ex_v & ~sb_mem_ld &
               hit(sb_mem_v, sb_mem_rw, sb_mem_rd, sb_ex_rs1, sb_ex_use1);
    ex_b_mem = (FWD_EN != 0) & sb_ex_v & ~sb_mem_ld &
               hit(sb_mem_v, sb_mem_rw, sb_mem_rd, sb_ex_rs2, sb_ex_use2);
    ex_a_wb  = (FWD_EN != 0) & sb_ex_v & hit(sb_wb_v, sb_wb_rw, sb_wb_rd, sb_ex_rs1, sb_ex_use1);
    ex_b_wb  = (FWD_EN != 0) & sb_ex_v & hit(sb_wb_v, sb_wb_rw, sb_wb_rd, sb_ex_rs2, sb_ex_use2);
    fwd_a  = ex_a_mem ? 2'b10 : (ex_a_wb ? 2'b01 : 2'b00);
    fwd_b  = ex_b_mem ? 2'b10 : (ex_b_wb ? 2'b01 : 2'b00);
    ex_opa = ex_a_mem ? mem_result : (ex_a_wb ? wb_result : ex_rd1);
    ex_opb = ex_b_mem ? mem_result : (ex_b_wb ? wb_result : ex_rd2);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sb_ex_v <= 1'b0; sb_ex_use1 <= 1'b0; sb_ex_use2 <= 1'b0; sb_ex_rw <= 1'b0; sb_ex_ld <= 1'b0;
      sb_ex_rd <= '0; sb_ex_rs1 <= '0; sb_ex_rs2 <= '0;
      sb_mem_v <= 1'b0; sb_mem_rw <= 1'b0; sb_mem_ld <= 1'b0; sb_mem_rd <= '0;
      sb_wb_v <= 1'b0; sb_wb_rw <= 1'b0; sb_wb_rd <= '0;
    end else if (pipe_en) begin
      sb_wb_v   <= sb_mem_v;
      sb_wb_rw  <= sb_mem_rw;
      sb_wb_rd  <= sb_mem_rd;
      sb_mem_v  <= sb_ex_v & ~exmem_clr;
      sb_mem_rw <= sb_ex_rw;
      sb_mem_ld <= sb_ex_ld;
      sb_mem_rd <= sb_ex_rd;
      if (idex_clr) begin
        sb_ex_v <= 1'b0; sb_ex_use1 <= 1'b0; sb_ex_use2 <= 1'b0; sb_ex_rw <= 1'b0; sb_ex_ld <= 1'b0;
        sb_ex_rd <= '0; sb_ex_rs1 <= '0; sb_ex_rs2 <= '0;
      end else begin
        sb_ex_v    <= id_valid;
        sb_ex_use1 <= id_use1;
        sb_ex_use2 <= id_use2;
        sb_ex_rw   <= id_regwrite;
        sb_ex_ld   <= id_memread;
        sb_ex_rd   <= id_rd;
        sb_ex_rs1  <= id_rs1;
        sb_ex_rs2  <= id_rs2;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (do_stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_ONE;
      if (do_flush && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_rv_hazard_ctrl.sv
// Directed bench for rv_hazard_ctrl: default, MEM-resolved-branch (narrow counters)
// and no-forwarding instances driven by the same ID stream.
module tb_rv_hazard_ctrl;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        id_valid, id_use1, id_use2, id_regwrite, id_memread;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        br_taken, mem_wait;
  logic [31:0] ex_rd1, ex_rd2, mem_result, wb_result;

  logic        d_pc_en, d_ifid_en, d_ifid_clr, d_idex_clr, d_exmem_clr, d_pipe_en;
  logic [1:0]  d_fwd_a, d_fwd_b;
  logic [31:0] d_ex_opa, d_ex_opb;
  logic [15:0] d_stall_cnt, d_flush_cnt;

  logic        b_pc_en, b_ifid_en, b_ifid_clr, b_idex_clr, b_exmem_clr, b_pipe_en;
  logic [1:0]  b_fwd_a, b_fwd_b;
  logic [31:0] b_ex_opa, b_ex_opb;
  logic [1:0]  b_stall_cnt, b_flush_cnt;

  logic        n_pc_en, n_ifid_en, n_ifid_clr, n_idex_clr, n_exmem_clr, n_pipe_en;
  logic [1:0]  n_fwd_a, n_fwd_b;
  logic [31:0] n_ex_opa, n_ex_opb;
  logic [15:0] n_stall_cnt, n_flush_cnt;

  int vec_count = 0;
  int err_count = 0;

  always #5 CLK = ~CLK;

  rv_hazard_ctrl u_def (
    .CLK(CLK), .RESET_N(RESET_N), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use1(id_use1), .id_use2(id_use2), .id_rd(id_rd), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .br_taken(br_taken), .mem_wait(mem_wait), .ex_rd1(ex_rd1),
    .ex_rd2(ex_rd2), .mem_result(mem_result), .wb_result(wb_result), .pc_en(d_pc_en),
    .ifid_en(d_ifid_en), .ifid_clr(d_ifid_clr), .idex_clr(d_idex_clr), .exmem_clr(d_exmem_clr),
    .pipe_en(d_pipe_en), .fwd_a(d_fwd_a), .fwd_b(d_fwd_b), .ex_opa(d_ex_opa), .ex_opb(d_ex_opb),
    .stall_cnt(d_stall_cnt), .flush_cnt(d_flush_cnt));

  rv_hazard_ctrl #(.BR_STAGE(3), .CNT_W(2)) u_br3 (
    .CLK(CLK), .RESET_N(RESET_N), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use1(id_use1), .id_use2(id_use2), .id_rd(id_rd), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .br_taken(br_taken), .mem_wait(mem_wait), .ex_rd1(ex_rd1),
    .ex_rd2(ex_rd2), .mem_result(mem_result), .wb_result(wb_result), .pc_en(b_pc_en),
    .ifid_en(b_ifid_en), .ifid_clr(b_ifid_clr), .idex_clr(b_idex_clr), .exmem_clr(b_exmem_clr),
    .pipe_en(b_pipe_en), .fwd_a(b_fwd_a), .fwd_b(b_fwd_b), .ex_opa(b_ex_opa), .ex_opb(b_ex_opb),
    .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt));

  rv_hazard_ctrl #(.FWD_EN(0), .RF_BYPASS(1)) u_nofwd (
    .CLK(CLK), .RESET_N(RESET_N), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use1(id_use1), .id_use2(id_use2), .id_rd(id_rd), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .br_taken(br_taken), .mem_wait(mem_wait), .ex_rd1(ex_rd1),
    .ex_rd2(ex_rd2), .mem_result(mem_result), .wb_result(wb_result), .pc_en(n_pc_en),
    .ifid_en(n_ifid_en), .ifid_clr(n_ifid_clr), .idex_clr(n_idex_clr), .exmem_clr(n_exmem_clr),
    .pipe_en(n_pipe_en), .fwd_a(n_fwd_a), .fwd_b(n_fwd_b), .ex_opa(n_ex_opa), .ex_opb(n_ex_opb),
    .stall_cnt(n_stall_cnt), .flush_cnt(n_flush_cnt));

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_count++;
    if (got !== exp) begin
      err_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Called right after a falling edge; outputs settle before the #1 check point
  task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic u1,
                               input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                               input logic rw, input logic mr);
    id_valid = v; id_rs1 = rs1; id_use1 = u1; id_rs2 = rs2; id_use2 = u2;
    id_rd = rd; id_regwrite = rw; id_memread = mr;
    #1;
  endtask

  task automatic nop();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic nextCycle();
    @(negedge CLK);
  endtask

  task automatic doReset();
    RESET_N = 1'b0; br_taken = 1'b0; mem_wait = 1'b0;
    nop();
    @(negedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  initial begin
    RESET_N = 1'b0; br_taken = 1'b0; mem_wait = 1'b0;
    ex_rd1 = 32'h1111_1111; ex_rd2 = 32'h2222_2222;
    mem_result = 32'hAAAA_AAAA; wb_result = 32'hBBBB_BBBB;
    nop();
    @(negedge CLK); #1;
    checkOutput("rst_pc_en", d_pc_en, 1);
    checkOutput("rst_ifid_en", d_ifid_en, 1);
    checkOutput("rst_pipe_en", d_pipe_en, 1);
    checkOutput("rst_clears", {d_ifid_clr, d_idex_clr, d_exmem_clr}, 0);
    checkOutput("rst_fwd", {d_fwd_a, d_fwd_b}, 0);
    checkOutput("rst_opa", d_ex_opa, 32'h1111_1111);
    checkOutput("rst_opb", d_ex_opb, 32'h2222_2222);
    checkOutput("rst_cnts", {d_stall_cnt, d_flush_cnt}, 0);
    @(negedge CLK);
    RESET_N = 1'b1;

    // addi x5,x0,1 ; add x6,x5,x5 -> both operands from MEM
    applyStimulus(1, 5'd0, 1, 5'd0, 0, 5'd5, 1, 0);
    checkOutput("alu_addi_pc_en", d_pc_en, 1); nextCycle();
    applyStimulus(1, 5'd5, 1, 5'd5, 1, 5'd6, 1, 0);
    checkOutput("alu_add_pc_en", d_pc_en, 1);
    checkOutput("alu_add_idex_clr", d_idex_clr, 0); nextCycle();
    nop();
    checkOutput("alu_fwd_a", d_fwd_a, 2'b10);
    checkOutput("alu_fwd_b", d_fwd_b, 2'b10);
    checkOutput("alu_opa", d_ex_opa, 32'hAAAA_AAAA);
    checkOutput("alu_opb", d_ex_opb, 32'hAAAA_AAAA); nextCycle();

    // lw x7,0(x0) ; add x8,x7,x1 -> one bubble then WB forward
    applyStimulus(1, 5'd0, 1, 5'd0, 0, 5'd7, 1, 1);
    checkOutput("lu_lw_pc_en", d_pc_en, 1); nextCycle();
    applyStimulus(1, 5'd7, 1, 5'd1, 1, 5'd8, 1, 0);
    checkOutput("lu_stall_pc_en", d_pc_en, 0);
    checkOutput("lu_stall_ifid_en", d_ifid_en, 0);
    checkOutput("lu_stall_idex_clr", d_idex_clr, 1);
    checkOutput("lu_stall_pipe_en", d_pipe_en, 1); nextCycle();
    applyStimulus(1, 5'd7, 1, 5'd1, 1, 5'd8, 1, 0);
    checkOutput("lu_go_pc_en", d_pc_en, 1);
    checkOutput("lu_go_idex_clr", d_idex_clr, 0);
    checkOutput("lu_stall_cnt", d_stall_cnt, 1); nextCycle();
    nop();
    checkOutput("lu_fwd_a", d_fwd_a, 2'b01);
    checkOutput("lu_opa", d_ex_opa, 32'hBBBB_BBBB);
    checkOutput("lu_fwd_b", d_fwd_b, 2'b00);
    checkOutput("lu_opb", d_ex_opb, 32'h2222_2222); nextCycle();

    // add x0,x1,x2 ; add x3,x0,x0 -> x0 is never a source of hazard
    applyStimulus(1, 5'd1, 1, 5'd2, 1, 5'd0, 1, 0); nextCycle();
    applyStimulus(1, 5'd0, 1, 5'd0, 1, 5'd3, 1, 0);
    checkOutput("x0_pc_en", d_pc_en, 1); nextCycle();
    nop();
    checkOutput("x0_fwd", {d_fwd_a, d_fwd_b}, 0);
    checkOutput("x0_opa", d_ex_opa, 32'h1111_1111); nextCycle();

    // Taken branch on top of a load-use hazard: flush wins, stall not counted
    doReset();
    applyStimulus(1, 5'd0, 1, 5'd0, 0, 5'd7, 1, 1); nextCycle();
    br_taken = 1'b1;
    applyStimulus(1, 5'd7, 1, 5'd1, 1, 5'd8, 1, 0);
    checkOutput("br_pc_en", d_pc_en, 1);
    checkOutput("br_ifid_clr", d_ifid_clr, 1);
    checkOutput("br_idex_clr", d_idex_clr, 1);
    checkOutput("br_exmem_clr_ex", d_exmem_clr, 0);
    checkOutput("br_exmem_clr_mem", b_exmem_clr, 1); nextCycle();
    br_taken = 1'b0;
    nop();
    checkOutput("br_ifid_clr_off", d_ifid_clr, 0);
    checkOutput("br_flush_cnt", d_flush_cnt, 1);
    checkOutput("br_flush_cnt_b3", b_flush_cnt, 1);
    checkOutput("br_stall_cnt", d_stall_cnt, 0); nextCycle();
    for (int i = 0; i < 4; i++) begin
      br_taken = 1'b1; nop(); nextCycle();
    end
    br_taken = 1'b0;
    nop();
    checkOutput("sat_flush_cnt", d_flush_cnt, 5);
    checkOutput("sat_flush_cnt_b3", b_flush_cnt, 3); nextCycle();

    // No forwarding: addi x5 ; add x6,x5,x0 waits until x5 reaches WB
    doReset();
    applyStimulus(1, 5'd0, 1, 5'd0, 0, 5'd5, 1, 0);
    checkOutput("nf_addi_pc_en", n_pc_en, 1); nextCycle();
    applyStimulus(1, 5'd5, 1, 5'd0, 1, 5'd6, 1, 0);
    checkOutput("nf_stall1_pc_en", n_pc_en, 0);
    checkOutput("nf_stall1_idex_clr", n_idex_clr, 1);
    checkOutput("nf_def_no_stall", d_pc_en, 1); nextCycle();
    applyStimulus(1, 5'd5, 1, 5'd0, 1, 5'd6, 1, 0);
    checkOutput("nf_stall2_pc_en", n_pc_en, 0); nextCycle();
    applyStimulus(1, 5'd5, 1, 5'd0, 1, 5'd6, 1, 0);
    checkOutput("nf_go_pc_en", n_pc_en, 1);
    checkOutput("nf_stall_cnt", n_stall_cnt, 2); nextCycle();
    nop();
    checkOutput("nf_fwd_a", n_fwd_a, 2'b00);
    checkOutput("nf_stall_cnt_hold", n_stall_cnt, 2); nextCycle();
    applyStimulus(1, 5'd1, 1, 5'd2, 1, 5'd0, 1, 0); nextCycle();
    applyStimulus(1, 5'd0, 1, 5'd0, 1, 5'd3, 1, 0);
    checkOutput("nf_x0_pc_en", n_pc_en, 1); nextCycle();

    // mem_wait freezes a pending load-use stall; branch ignored while frozen
    doReset();
    applyStimulus(1, 5'd0, 1, 5'd0, 0, 5'd7, 1, 1); nextCycle();
    mem_wait = 1'b1;
    for (int i = 0; i < 3; i++) begin
      br_taken = (i == 1);
      applyStimulus(1, 5'd7, 1, 5'd1, 1, 5'd8, 1, 0);
      checkOutput("mw_enables", {d_pc_en, d_ifid_en, d_pipe_en}, 3'b000);
      checkOutput("mw_clears", {d_ifid_clr, d_idex_clr, d_exmem_clr}, 3'b000);
      nextCycle();
    end
    mem_wait = 1'b0; br_taken = 1'b0;
    applyStimulus(1, 5'd7, 1, 5'd1, 1, 5'd8, 1, 0);
    checkOutput("mw_cnts_frozen", {d_stall_cnt, d_flush_cnt}, 0);
    checkOutput("mw_rel_pc_en", d_pc_en, 0);
    checkOutput("mw_rel_idex_clr", d_idex_clr, 1); nextCycle();
    applyStimulus(1, 5'd7, 1, 5'd1, 1, 5'd8, 1, 0);
    checkOutput("mw_go_pc_en", d_pc_en, 1);
    checkOutput("mw_stall_cnt", d_stall_cnt, 1); nextCycle();

    // Async reset in the middle of a load-use stall
    doReset();
    applyStimulus(1, 5'd0, 1, 5'd0, 0, 5'd7, 1, 1); nextCycle();
    applyStimulus(1, 5'd7, 1, 5'd1, 1, 5'd8, 1, 0);
    checkOutput("mr_pre_pc_en", d_pc_en, 0);
    #1 RESET_N = 1'b0;
    #1;
    checkOutput("mr_async_pc_en", d_pc_en, 1);
    @(negedge CLK);
    RESET_N = 1'b1;
    applyStimulus(1, 5'd7, 1, 5'd1, 1, 5'd8, 1, 0);
    checkOutput("mr_post_pc_en", d_pc_en, 1);
    checkOutput("mr_post_stall_cnt", d_stall_cnt, 0); nextCycle();

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
